// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte-strobe writes,
// SLVERR on unmapped words, contents and per-register write pulses exported to user logic.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
    input  logic [2:0]                     S_AWPROT,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
    input  logic [2:0]                     S_ARPROT,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                           aw_hold;
    logic                           w_hold;
    logic [IDX_W-1:0]               aw_idx_p1;
    logic [DATA_WIDTH-1:0]          w_data_p1;
    logic [STRB_W-1:0]              w_strb_p1;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]            aw_match;
    logic [IDX_W-1:0]               ar_idx;
    logic                           ar_hit;
    logic [DATA_WIDTH-1:0]          rd_mux;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           ar_hs;
    logic                           commit;
    logic                           unused_ok;

    // Ready terms are gated by ARESETN so they read 0 throughout reset.
    assign S_AWREADY = ARESETN && !aw_hold && !S_BVALID;
    assign S_WREADY  = ARESETN && !w_hold && !S_BVALID;
    assign S_ARREADY = ARESETN && !S_RVALID;

    assign aw_hs  = S_AWVALID && S_AWREADY;
    assign w_hs   = S_WVALID && S_WREADY;
    assign ar_hs  = S_ARVALID && S_ARREADY;
    assign commit = aw_hold && w_hold && !S_BVALID;
    assign ar_idx = S_ARADDR[ADDR_WIDTH-1:2];

    assign reg_out   = regs_q;
    assign unused_ok = ^{S_AWPROT, S_ARPROT, S_AWADDR[1:0], S_ARADDR[1:0]};

    // Word decode: an unmapped index matches nothing, which yields SLVERR and no update.
    always_comb begin
        aw_match = '0;
        ar_hit   = 1'b0;
        rd_mux   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            aw_match[k] = (aw_idx_p1 == IDX_W'(k));
            if (ar_idx == IDX_W'(k)) begin
                ar_hit = 1'b1;
                rd_mux = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage p1: AW/W capture; commit into the register file once both halves are held
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_hold      <= 1'b0;
            w_hold       <= 1'b0;
            aw_idx_p1    <= '0;
            w_data_p1    <= '0;
            w_strb_p1    <= '0;
            S_BVALID     <= 1'b0;
            S_BRESP      <= RESP_OKAY;
            reg_wr_pulse <= '0;
            regs_q       <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (aw_hs) begin
                aw_hold   <= 1'b1;
                aw_idx_p1 <= S_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_hold    <= 1'b1;
                w_data_p1 <= S_WDATA;
                w_strb_p1 <= S_WSTRB;
            end
            if (commit) begin
                aw_hold      <= 1'b0;
                w_hold       <= 1'b0;
                S_BVALID     <= 1'b1;
                S_BRESP      <= (|aw_match) ? RESP_OKAY : RESP_SLVERR;
                reg_wr_pulse <= aw_match;
                for (int k = 0; k < NUM_REGS; k++) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (aw_match[k] && w_strb_p1[b]) begin
                            regs_q[k*DATA_WIDTH + 8*b +: 8] <= w_data_p1[8*b +: 8];
                        end
                    end
                end
            end else if (S_BVALID && S_BREADY) begin
                S_BVALID <= 1'b0;
            end
        end
    end

    // Stage p1: read response; samples regs_q before any same-edge commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_RVALID <= 1'b0;
            S_RDATA  <= '0;
            S_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_RVALID <= 1'b1;
            S_RDATA  <= rd_mux;
            S_RRESP  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (S_RVALID && S_RREADY) begin
            S_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: a vector table of AXI-Lite reads/writes plus
// hand-written sequences for delayed W, response back-pressure and mid-transaction reset.
module tb_axil_reg_slave;
    logic         ACLK;
    logic         ARESETN;
    logic [4:0]   S_AWADDR;
    logic [2:0]   S_AWPROT;
    logic         S_AWVALID;
    logic         S_AWREADY;
    logic [31:0]  S_WDATA;
    logic [3:0]   S_WSTRB;
    logic         S_WVALID;
    logic         S_WREADY;
    logic [1:0]   S_BRESP;
    logic         S_BVALID;
    logic         S_BREADY;
    logic [4:0]   S_ARADDR;
    logic [2:0]   S_ARPROT;
    logic         S_ARVALID;
    logic         S_ARREADY;
    logic [31:0]  S_RDATA;
    logic [1:0]   S_RRESP;
    logic         S_RVALID;
    logic         S_RREADY;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int n_vec = 0;
    int n_bad = 0;
    int pcnt [4];

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        for (int k = 0; k < 4; k++) pcnt[k] += int'(reg_wr_pulse[k]);
    end

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_pulse;
    } vec_t;

    vec_t vecs [16];

    function automatic int pulse_total();
        return pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        bit awd, wd, aw_now, w_now;
        n = 0; awd = 0; wd = 0;
        S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        while (!(awd && wd) && n < 50) begin
            aw_now = S_AWREADY;
            w_now  = S_WREADY;
            @(posedge ACLK); #1;
            if (aw_now) begin awd = 1; S_AWVALID = 1'b0; end
            if (w_now)  begin wd = 1;  S_WVALID = 1'b0; end
            n++;
        end
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk("aw_w_handshake", {awd, wd}, 2'b11);
        S_BREADY = 1'b1;
        n = 0;
        while (!S_BVALID && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("bvalid_wait", S_BVALID, 1'b1);
        resp = S_BRESP;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit got;
        n = 0; got = 0;
        S_ARADDR = a; S_ARVALID = 1'b1;
        while (!got && n < 50) begin
            got = S_ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        S_ARVALID = 1'b0;
        chk("ar_handshake", got, 1'b1);
        chk("rd_latency", S_RVALID, 1'b1);
        d = S_RDATA;
        resp = S_RRESP;
        S_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_RREADY = 1'b0;
        chk("rvalid_clear", S_RVALID, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          p0;

        vecs[0]  = '{1'b0, 5'h00, 32'h0000_0001, 4'hF, 32'h0,          2'b00, 1};
        vecs[1]  = '{1'b0, 5'h04, 32'h0000_0002, 4'hF, 32'h0,          2'b00, 1};
        vecs[2]  = '{1'b0, 5'h08, 32'h0000_0003, 4'hF, 32'h0,          2'b00, 1};
        vecs[3]  = '{1'b0, 5'h0C, 32'h0000_0004, 4'hF, 32'h0,          2'b00, 1};
        vecs[4]  = '{1'b1, 5'h00, 32'h0,         4'h0, 32'h0000_0001,  2'b00, 0};
        vecs[5]  = '{1'b1, 5'h04, 32'h0,         4'h0, 32'h0000_0002,  2'b00, 0};
        vecs[6]  = '{1'b1, 5'h08, 32'h0,         4'h0, 32'h0000_0003,  2'b00, 0};
        vecs[7]  = '{1'b1, 5'h0C, 32'h0,         4'h0, 32'h0000_0004,  2'b00, 0};
        vecs[8]  = '{1'b0, 5'h04, 32'hAABB_CCDD, 4'hF, 32'h0,          2'b00, 1};
        vecs[9]  = '{1'b0, 5'h04, 32'h1122_3344, 4'h5, 32'h0,          2'b00, 1};
        vecs[10] = '{1'b1, 5'h04, 32'h0,         4'h0, 32'hAA22_CC44,  2'b00, 0};
        vecs[11] = '{1'b0, 5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b10, 0};
        vecs[12] = '{1'b1, 5'h14, 32'h0,         4'h0, 32'h0,          2'b10, 0};
        vecs[13] = '{1'b1, 5'h01, 32'h0,         4'h0, 32'h0000_0001,  2'b00, 0};
        vecs[14] = '{1'b0, 5'h0E, 32'h0000_0055, 4'h1, 32'h0,          2'b00, 1};
        vecs[15] = '{1'b1, 5'h0C, 32'h0,         4'h0, 32'h0000_0055,  2'b00, 0};

        ARESETN = 1'b0;
        S_AWADDR = '0; S_AWPROT = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
        S_ARADDR = '0; S_ARPROT = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_awready", S_AWREADY, 1'b0);
        chk("rst_wready", S_WREADY, 1'b0);
        chk("rst_arready", S_ARREADY, 1'b0);
        chk("rst_bvalid", S_BVALID, 1'b0);
        chk("rst_rvalid", S_RVALID, 1'b0);
        chk("rst_rdata", S_RDATA, 32'h0);
        chk("rst_reg_out", reg_out, 128'h0);
        chk("rst_pulse", reg_wr_pulse, 4'h0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        chk("idle_awready", S_AWREADY, 1'b1);
        chk("idle_arready", S_ARREADY, 1'b1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rd) begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("v%0d_rresp", i), rsp, vecs[i].exp_resp);
            end else begin
                p0 = pulse_total();
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                chk($sformatf("v%0d_bresp", i), rsp, vecs[i].exp_resp);
                chk($sformatf("v%0d_pulses", i), pulse_total() - p0, vecs[i].exp_pulse);
            end
            if (i == 7)
                chk("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);
        end
        chk("reg_out_table", reg_out, 128'h00000055_00000003_AA22CC44_00000001);
        chk("reg1_pulse_count", pcnt[1], 3);

        // AW in cycle 0, W held back until cycle 5
        p0 = pulse_total();
        @(posedge ACLK); #1;
        S_AWADDR = 5'h08; S_AWVALID = 1'b1;
        S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF; S_BREADY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) S_WVALID = 1'b1;
            chk($sformatf("dly_awready_c%0d", c), S_AWREADY, (c == 0));
            chk($sformatf("dly_wready_c%0d", c), S_WREADY, (c <= 5));
            chk($sformatf("dly_bvalid_c%0d", c), S_BVALID, (c >= 7));
            @(posedge ACLK); #1;
            if (c == 0) S_AWVALID = 1'b0;
            if (c == 5) S_WVALID = 1'b0;
        end
        chk("dly_pulses", pulse_total() - p0, 1);
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
        chk("dly_bvalid_clear", S_BVALID, 1'b0);
        axi_read(5'h08, rd, rsp);
        chk("dly_rdata", rd, 32'h1234_5678);

        // Second write presented while the first response is back-pressured
        @(posedge ACLK); #1;
        S_AWADDR = 5'h00; S_WDATA = 32'hA5A5_A5A5; S_WSTRB = 4'hF;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AWADDR = 5'h0C; S_WDATA = 32'h0F0F_0F0F;
        @(posedge ACLK); #1;
        chk("bp_reg0", reg_out[31:0], 32'hA5A5_A5A5);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_bvalid_c%0d", c), S_BVALID, 1'b1);
            chk($sformatf("bp_awready_c%0d", c), S_AWREADY, 1'b0);
            chk($sformatf("bp_wready_c%0d", c), S_WREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        chk("bp_reg3_held", reg_out[127:96], 32'h0000_0055);
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
        chk("bp_bvalid_drop", S_BVALID, 1'b0);
        chk("bp_awready_back", S_AWREADY, 1'b1);
        chk("bp_wready_back", S_WREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("bp_bvalid2", S_BVALID, 1'b1);
        chk("bp_reg3_new", reg_out[127:96], 32'h0F0F_0F0F);
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;

        // Reset lands between the AW and W handshakes
        @(posedge ACLK); #1;
        S_AWADDR = 5'h04; S_AWVALID = 1'b1; S_WDATA = 32'h7777_7777;
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        chk("mr_aw_held", S_AWREADY, 1'b0);
        #2 ARESETN = 1'b0;
        #1;
        chk("mr_awready", S_AWREADY, 1'b0);
        chk("mr_wready", S_WREADY, 1'b0);
        chk("mr_arready", S_ARREADY, 1'b0);
        chk("mr_bvalid", S_BVALID, 1'b0);
        chk("mr_reg_out", reg_out, 128'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge ACLK); #1;
            chk($sformatf("mr_no_bvalid_c%0d", c), S_BVALID, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(4 * k), rd, rsp);
            chk($sformatf("mr_reg%0d", k), rd, 32'h0);
            chk($sformatf("mr_rresp%0d", k), rsp, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite slave register file: the responder end of the bus driven by the master VIP in the block-design testbench.
- Holds NUM_REGS software-visible 32-bit registers, addressed on word boundaries, with byte-strobe writes.
- Returns SLVERR for out-of-range addresses.
- Exposes the register contents and a write-strobe pulse to user logic inside the IP.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 5, AXI address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; 1 to 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AWADDR  in  ADDR_WIDTH  write address.
- S_AWPROT  in  3  ignored.
- S_AWVALID  in  1  write address valid.
- S_AWREADY  out  1  write address ready.
- S_WDATA  in  32  write data.
- S_WSTRB  in  4  byte strobes.
- S_WVALID  in  1  write data valid.
- S_WREADY  out  1  write data ready.
- S_BRESP  out  2  write response (OKAY=00 / SLVERR=10).
- S_BVALID  out  1  write response valid.
- S_BREADY  in  1  write response ready.
- S_ARADDR  in  ADDR_WIDTH  read address.
- S_ARPROT  in  3  ignored.
- S_ARVALID  in  1  read address valid.
- S_ARREADY  out  1  read address ready.
- S_RDATA  out  32  read data.
- S_RRESP  out  2  read response.
- S_RVALID  out  1  read data valid.
- S_RREADY  in  1  read data ready.
- reg_out  out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register on commit.

Behaviour:
- Clock ACLK; reset ARESETN is asynchronous, active-low.
- Reset values (async assert, sync release): all registers 0, aw_hold=w_hold=0, S_BVALID=0, S_RVALID=0, S_BRESP=00, S_RRESP=00, S_RDATA=0, reg_wr_pulse=0. S_AWREADY/S_WREADY/S_ARREADY are 0 while ARESETN=0.
- Write path, address and data accepted independently in any order:
  - S_AWREADY = !aw_hold && !S_BVALID. The AW handshake latches the address and sets aw_hold.
  - S_WREADY = !w_hold && !S_BVALID. The W handshake latches data and strobes and sets w_hold.
  - Commit fires on the edge where aw_hold && w_hold (registered) && !S_BVALID:
    - byte lanes with WSTRB=1 are updated;
    - aw_hold and w_hold are cleared;
    - S_BVALID=1 is set;
    - reg_wr_pulse[idx]=1 for exactly that cycle.
  - Latency: AW and W both accepted at edge T -> registers and S_BVALID update at edge T+1.
  - S_BVALID holds, with S_BRESP stable, until S_BREADY=1. No new AW/W is accepted while S_BVALID=1.
  - Out of range (idx >= NUM_REGS): no register change, no pulse, S_BRESP=10.
- Read path:
  - S_ARREADY = !S_RVALID.
  - At the AR handshake edge: S_RDATA = reg[idx] (0 if out of range), S_RRESP = 00 or 10, S_RVALID=1. Read latency is 1 cycle.
  - S_RVALID and S_RDATA hold until S_RREADY=1. On the same edge as S_RREADY && S_RVALID a new AR may not be accepted; ARREADY rises the following cycle. Maximum throughput is one read per 2 cycles.
- Read and write paths are independent. If a read samples the same edge as a commit to the same register, the read returns the pre-write value.
- Unaligned address bits [1:0] are ignored. PROT is ignored.
- Reset asserted mid-transaction: outstanding AW/W/AR are dropped, no B/R response is issued, and registers return to 0.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC; read the same addresses -> RDATA 0x1..0x4, all BRESP/RRESP=00, reg_out=0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x4 with WSTRB=1111, then 0x11223344 with WSTRB=0101 -> read 0x4 = 0xAA22CC44; reg_wr_pulse[1] high exactly one cycle per write.
- AWVALID at cycle 0, WVALID delayed to cycle 5 -> AWREADY drops after cycle 0, BVALID first seen cycle 7, one write only.
- Write to 0x10 and read 0x14 -> BRESP=10 and RRESP=10 with RDATA=0, registers unchanged, no reg_wr_pulse.
- Hold BREADY=0 for 10 cycles with a second AW/W presented -> BVALID stays 1, AWREADY/WREADY stay 0; second write commits only after BREADY.
- Assert ARESETN=0 between AW and W handshakes -> all outputs 0 immediately, no BVALID after release, reg 0..3 read 0.
